mdu_unit: RTL

Multiply/divide unit for the 5-stage MIPS pipeline. It is the responder to the Execute stage's `start` request and reports `busy` back to the hazard unit. It performs mult/multu/div/divu with fixed multi-cycle latency, owns the HI/LO registers, and services mthi/mtlo writes. HI/LO are exposed to the Execute stage for mfhi/mflo.

---
 rtl/mdu_defs.sv | 24 ++
 rtl/mdu_calc.sv | 69 ++++++
 rtl/mdu_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/mdu_defs.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// default latencies.
package mdu_defs;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        DIV   = 3'd3,
        DIVU  = 3'd4,
        MTHI  = 3'd5,
        MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;
    localparam int CNT_W_DEF      = 4;

endpackage

// File: rtl/mdu_calc.sv
// Combinational 32x32 multiply and 32/32 divide producing the HI/LO pair.
// res_valid is low for divide-by-zero and for anything that is not arithmetic.
module mdu_calc
    import mdu_defs::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_valid
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic [31:0] quo_m;
    logic [31:0] rem_m;
    logic        div_zero;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{32{inA[31]}}, inA} * {{32{inB[31]}}, inB};
    assign prod_u = {32'd0, inA} * {32'd0, inB};

    // Divisor forced non-zero so the dividers never see zero; result is dropped anyway.
    assign div_zero = (inB == 32'd0);
    assign div_b    = div_zero ? 32'd1 : inB;
    assign abs_a    = inA[31] ? (32'd0 - inA) : inA;
    assign abs_b    = div_b[31] ? (32'd0 - div_b) : div_b;
    assign quo_u    = inA / div_b;
    assign rem_u    = inA % div_b;
    assign quo_m    = abs_a / abs_b;
    assign rem_m    = abs_a % abs_b;

    // Signed divide on magnitudes: 0x80000000 / -1 naturally wraps to 0x80000000, rem 0.
    always_comb begin
        res_hi    = 32'd0;
        res_lo    = 32'd0;
        res_valid = 1'b0;
        case (op)
            MULT: begin
                res_hi    = prod_s[63:32];
                res_lo    = prod_s[31:0];
                res_valid = 1'b1;
            end
            MULTU: begin
                res_hi    = prod_u[63:32];
                res_lo    = prod_u[31:0];
                res_valid = 1'b1;
            end
            DIV: begin
                res_lo    = (inA[31] ^ div_b[31]) ? (32'd0 - quo_m) : quo_m;
                res_hi    = inA[31] ? (32'd0 - rem_m) : rem_m;
                res_valid = !div_zero;
            end
            DIVU: begin
                res_lo    = quo_u;
                res_hi    = rem_u;
                res_valid = !div_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit: fixed-latency mult/div sequencer owning HI/LO.
// Requires 2**CNT_W > max(MUL_CYCLES, DIV_CYCLES), both at least 1.
module mdu_unit
    import mdu_defs::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);

    // Handshake: start is a single-cycle request honoured only while busy==0;
    // busy rises the cycle after an accepted mult/div and falls when HI/LO are
    // updated, with done pulsing in that first non-busy cycle.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    mdu_op_e          op;
    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic             res_valid_q, res_valid_d;
    logic             done_q, done_d;
    logic [31:0]      calc_hi, calc_lo;
    logic             calc_valid;

    assign op = mdu_op_e'(mdu_op);

    mdu_calc u_calc (
        .op        (op),
        .inA       (inA),
        .inB       (inB),
        .res_hi    (calc_hi),
        .res_lo    (calc_lo),
        .res_valid (calc_valid)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        res_hi_d    = res_hi_q;
        res_lo_d    = res_lo_q;
        res_valid_d = res_valid_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        MULT, MULTU, DIV, DIVU: begin
                            res_hi_d    = calc_hi;
                            res_lo_d    = calc_lo;
                            res_valid_d = calc_valid;
                            cnt_d       = (op == MULT || op == MULTU) ? MUL_LOAD : DIV_LOAD;
                            state_d     = RUN;
                        end
                        MTHI:    hi_d = inA;
                        MTLO:    lo_d = inA;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Any start seen here is dropped; the hazard unit stalls Execute.
                if (cnt_q == '0) begin
                    if (res_valid_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            res_hi_q    <= 32'd0;
            res_lo_q    <= 32'd0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            res_hi_q    <= res_hi_d;
            res_lo_q    <= res_lo_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule
